// File: rtl/ieee1500_wsp_ctrl_if.sv
// IEEE 1500 Wrapper Serial Port signal bundle between the ATE side (master)
// and the WSP controller (slave).
interface ieee1500_wsp_ctrl_if;
  logic wsi;
  logic wso;
  logic select_wir;
  logic capture_wr;
  logic shift_wr;
  logic update_wr;

  modport master (
    output wsi,
    output select_wir,
    output capture_wr,
    output shift_wr,
    output update_wr,
    input  wso
  );

  modport slave (
    input  wsi,
    input  select_wir,
    input  capture_wr,
    input  shift_wr,
    input  update_wr,
    output wso
  );
endinterface

// File: rtl/ieee1500_wsp_ctrl.sv
// IEEE 1500 WSP controller in front of the SRAM MBIST wrapper: WIR/WCR/WDR/bypass
// chains plus MBIST run tracking. Define WSO_RETIME_EN to register wso.
module ieee1500_wsp_ctrl #(
  parameter int WIR_WIDTH = 3,
  parameter int WCR_WIDTH = 8,
  parameter int WDR_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  ieee1500_wsp_ctrl_if.slave   wsp,
  output logic [WCR_WIDTH-1:0] o_wcr_in,
  input  logic [WCR_WIDTH-1:0] i_wcr_out,
  output logic [WDR_WIDTH-1:0] o_wdr_in,
  input  logic [WDR_WIDTH-1:0] i_wdr_out,
  output logic                 o_mbist_enable,
  output logic                 o_start_bist,
  input  logic                 i_bist_done
);

  localparam logic [WIR_WIDTH-1:0] OP_BYPASS  = WIR_WIDTH'(0);
  localparam logic [WIR_WIDTH-1:0] OP_WS_CTRL = WIR_WIDTH'(1);
  localparam logic [WIR_WIDTH-1:0] OP_WS_DATA = WIR_WIDTH'(2);

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } run_state_t;

  logic [WIR_WIDTH-1:0] r_wir_shift;
  logic [WIR_WIDTH-1:0] r_wir_upd;
  logic                 r_bypass;
  logic [WCR_WIDTH-1:0] r_wcr_shift;
  logic [WCR_WIDTH-1:0] r_wcr_upd;
  logic [WDR_WIDTH-1:0] r_wdr_shift;
  logic [WDR_WIDTH-1:0] r_wdr_upd;
  logic                 r_start;
  run_state_t           r_run_state;

  logic w_sel_ctrl;
  logic w_sel_data;
  logic w_sel_bypass;
  logic w_do_capture;
  logic w_do_shift;
  logic w_do_update;
  logic w_start_req;
  logic w_wso_sel;
  logic w_unused_wcr_hi;

  // Only the highest-priority strobe acts: capture, then shift, then update.
  assign w_do_capture = wsp.capture_wr;
  assign w_do_shift   = wsp.shift_wr && !wsp.capture_wr;
  assign w_do_update  = wsp.update_wr && !wsp.shift_wr && !wsp.capture_wr;

  assign w_sel_ctrl   = !wsp.select_wir && (r_wir_upd == OP_WS_CTRL);
  assign w_sel_data   = !wsp.select_wir && (r_wir_upd == OP_WS_DATA);
  assign w_sel_bypass = !wsp.select_wir && !(r_wir_upd == OP_WS_CTRL)
                        && !(r_wir_upd == OP_WS_DATA);

  assign w_unused_wcr_hi = ^i_wcr_out[WCR_WIDTH-1:WCR_WIDTH-2];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wir_shift <= OP_BYPASS;
      r_wir_upd   <= OP_BYPASS;
    end else if (wsp.select_wir) begin
      if (w_do_capture)
        r_wir_shift <= r_wir_upd;
      else if (w_do_shift)
        r_wir_shift <= {wsp.wsi, r_wir_shift[WIR_WIDTH-1:1]};
      else if (w_do_update)
        r_wir_upd <= r_wir_shift;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_bypass <= 1'b0;
    else if (w_sel_bypass) begin
      if (w_do_capture)
        r_bypass <= 1'b0;
      else if (w_do_shift)
        r_bypass <= wsp.wsi;
    end
  end

  // Run state rides in the top two captured bits so the ATE can poll progress.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wcr_shift <= '0;
      r_wcr_upd   <= '0;
    end else if (w_sel_ctrl) begin
      if (w_do_capture)
        r_wcr_shift <= {r_run_state, i_wcr_out[WCR_WIDTH-3:0]};
      else if (w_do_shift)
        r_wcr_shift <= {wsp.wsi, r_wcr_shift[WCR_WIDTH-1:1]};
      else if (w_do_update)
        r_wcr_upd <= r_wcr_shift;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wdr_shift <= '0;
      r_wdr_upd   <= '0;
    end else if (w_sel_data) begin
      if (w_do_capture)
        r_wdr_shift <= i_wdr_out;
      else if (w_do_shift)
        r_wdr_shift <= {wsp.wsi, r_wdr_shift[WDR_WIDTH-1:1]};
      else if (w_do_update)
        r_wdr_upd <= r_wdr_shift;
    end
  end

  assign w_start_req = w_do_update && w_sel_ctrl && r_wcr_shift[1]
                       && r_wcr_shift[0] && (r_run_state != ST_RUN);

  // Dropping mbist_enable forces IDLE ahead of any other transition.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_start     <= 1'b0;
      r_run_state <= ST_IDLE;
    end else begin
      r_start <= w_start_req;
      if (!r_wcr_upd[0])
        r_run_state <= ST_IDLE;
      else begin
        case (r_run_state)
          ST_IDLE: if (r_start) r_run_state <= ST_RUN;
          ST_RUN:  if (i_bist_done) r_run_state <= ST_DONE;
          ST_DONE: if (r_start) r_run_state <= ST_RUN;
          default: r_run_state <= ST_IDLE;
        endcase
      end
    end
  end

  always_comb begin
    w_wso_sel = r_bypass;
    if (wsp.select_wir)
      w_wso_sel = r_wir_shift[0];
    else if (w_sel_ctrl)
      w_wso_sel = r_wcr_shift[0];
    else if (w_sel_data)
      w_wso_sel = r_wdr_shift[0];
  end

`ifdef WSO_RETIME_EN
  logic r_wso;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_wso <= 1'b0;
    else
      r_wso <= w_wso_sel;
  end

  assign wsp.wso = r_wso;
`else
  assign wsp.wso = w_wso_sel;
`endif

  assign o_wcr_in       = r_wcr_upd;
  assign o_wdr_in       = r_wdr_upd;
  assign o_mbist_enable = r_wcr_upd[0];
  assign o_start_bist   = r_start;

endmodule

// File: tb/tb_ieee1500_wsp_ctrl.sv
// Directed self-checking bench for ieee1500_wsp_ctrl (combinational wso build).
module tb_ieee1500_wsp_ctrl;
  logic        clk;
  logic        rst_n;
  logic [7:0]  wcrIn;
  logic [7:0]  wcrOut;
  logic [31:0] wdrIn;
  logic [31:0] wdrOut;
  logic        mbistEnable;
  logic        startBist;
  logic        bistDone;
  int          checkCount = 0;
  int          errorCount = 0;
  logic [31:0] readBack;
  int          pulses;

  ieee1500_wsp_ctrl_if wsp ();

  ieee1500_wsp_ctrl #(
    .WIR_WIDTH(3),
    .WCR_WIDTH(8),
    .WDR_WIDTH(32)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .wsp            (wsp.slave),
    .o_wcr_in       (wcrIn),
    .i_wcr_out      (wcrOut),
    .o_wdr_in       (wdrIn),
    .i_wdr_out      (wdrOut),
    .o_mbist_enable (mbistEnable),
    .o_start_bist   (startBist),
    .i_bist_done    (bistDone)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, actual, expected);
    end
  endtask

  task automatic stepClock();
    @(posedge clk);
    #1;
  endtask

  // One clock with the given strobes, then all strobes dropped.
  task automatic applyStimulus(input logic selWir, input logic cap, input logic sh,
                               input logic upd, input logic wsiBit);
    wsp.select_wir = selWir;
    wsp.capture_wr = cap;
    wsp.shift_wr   = sh;
    wsp.update_wr  = upd;
    wsp.wsi        = wsiBit;
    stepClock();
    wsp.select_wir = 1'b0;
    wsp.capture_wr = 1'b0;
    wsp.shift_wr   = 1'b0;
    wsp.update_wr  = 1'b0;
    wsp.wsi        = 1'b0;
  endtask

  // LSB-first shift; dout[i] is wso seen just before the i-th shift edge.
  task automatic shiftChain(input logic selWir, input int n, input logic [31:0] din,
                            output logic [31:0] dout);
    dout = '0;
    for (int i = 0; i < n; i++) begin
      wsp.select_wir = selWir;
      wsp.shift_wr   = 1'b1;
      wsp.wsi        = din[i];
      #1;
      dout[i] = wsp.wso;
      stepClock();
    end
    wsp.shift_wr   = 1'b0;
    wsp.select_wir = 1'b0;
    wsp.wsi        = 1'b0;
  endtask

  task automatic loadWir(input logic [2:0] op);
    logic [31:0] unusedOut;
    shiftChain(1'b1, 3, {29'b0, op}, unusedOut);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic countStarts(input int cycles, output int count);
    count = 0;
    for (int i = 0; i < cycles; i++) begin
      if (startBist === 1'b1) count++;
      stepClock();
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    rst_n          = 1'b0;
    wsp.wsi        = 1'b0;
    wsp.select_wir = 1'b0;
    wsp.capture_wr = 1'b0;
    wsp.shift_wr   = 1'b0;
    wsp.update_wr  = 1'b0;
    wcrOut         = 8'h00;
    wdrOut         = 32'h0;
    bistDone       = 1'b0;
    #12;
    checkOutput("rst_wso", {31'b0, wsp.wso}, 32'h0);
    checkOutput("rst_wcr_in", {24'b0, wcrIn}, 32'h0);
    checkOutput("rst_wdr_in", wdrIn, 32'h0);
    checkOutput("rst_mbist_en", {31'b0, mbistEnable}, 32'h0);
    checkOutput("rst_start", {31'b0, startBist}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    stepClock();

    $display("[TB] reset WIR readback");
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    shiftChain(1'b1, 3, 32'h0, readBack);
    checkOutput("rst_wir", readBack, 32'h0);

    $display("[TB] WDR write and read");
    loadWir(3'b010);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    shiftChain(1'b1, 3, 32'h2, readBack);
    checkOutput("wir_data", readBack, 32'h2);
    shiftChain(1'b0, 32, 32'hA5A5_F00D, readBack);
    checkOutput("wdr_rst_shift", readBack, 32'h0);
    checkOutput("wdr_pre_upd", wdrIn, 32'h0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    checkOutput("wdr_in", wdrIn, 32'hA5A5_F00D);
    wdrOut = 32'h1234_5678;
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    shiftChain(1'b0, 32, 32'h0, readBack);
    checkOutput("wdr_capture", readBack, 32'h1234_5678);

    $display("[TB] WCR start sequencing");
    loadWir(3'b001);
    shiftChain(1'b0, 8, 32'h03, readBack);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    checkOutput("wcr_in_03", {24'b0, wcrIn}, 32'h03);
    checkOutput("mbist_en_on", {31'b0, mbistEnable}, 32'h1);
    checkOutput("start_now", {31'b0, startBist}, 32'h1);
    countStarts(4, pulses);
    checkOutput("start_pulses", pulses, 1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    countStarts(4, pulses);
    checkOutput("start_in_run", pulses, 0);
    wcrOut = 8'h0C;
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    shiftChain(1'b0, 8, 32'h03, readBack);
    checkOutput("wcr_run", readBack, 32'h4C);

    bistDone = 1'b1;
    stepClock();
    bistDone = 1'b0;
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    shiftChain(1'b0, 8, 32'h03, readBack);
    checkOutput("wcr_done", readBack, 32'h8C);

    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    countStarts(4, pulses);
    checkOutput("restart_pulses", pulses, 1);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    shiftChain(1'b0, 8, 32'h00, readBack);
    checkOutput("wcr_rerun", readBack, 32'h4C);

    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    checkOutput("mbist_en_off", {31'b0, mbistEnable}, 32'h0);
    countStarts(3, pulses);
    checkOutput("no_start_off", pulses, 0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    shiftChain(1'b0, 8, 32'h00, readBack);
    checkOutput("wcr_idle", readBack, 32'h0C);

    $display("[TB] unknown opcode acts as bypass");
    loadWir(3'b101);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    shiftChain(1'b0, 4, 32'hB, readBack);
    checkOutput("bypass_wso", readBack, 32'h6);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    checkOutput("byp_wcr_in", {24'b0, wcrIn}, 32'h00);
    checkOutput("byp_wdr_in", wdrIn, 32'hA5A5_F00D);

    $display("[TB] capture beats update");
    loadWir(3'b010);
    shiftChain(1'b0, 32, 32'hDEAD_BEEF, readBack);
    wdrOut = 32'hCAFE_F00D;
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    checkOutput("cap_upd_wdr_in", wdrIn, 32'hA5A5_F00D);
    shiftChain(1'b0, 32, 32'h0, readBack);
    checkOutput("cap_upd_data", readBack, 32'hCAFE_F00D);

    $display("[TB] reset in the middle of a shift");
    loadWir(3'b001);
    shiftChain(1'b0, 8, 32'h01, readBack);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    checkOutput("pre_rst_wcr", {24'b0, wcrIn}, 32'h01);
    wsp.shift_wr = 1'b1;
    wsp.wsi      = 1'b1;
    stepClock();
    stepClock();
    stepClock();
    rst_n = 1'b0;
    #1;
    checkOutput("mid_rst_wso", {31'b0, wsp.wso}, 32'h0);
    checkOutput("mid_rst_wcr", {24'b0, wcrIn}, 32'h0);
    checkOutput("mid_rst_wdr", wdrIn, 32'h0);
    checkOutput("mid_rst_en", {31'b0, mbistEnable}, 32'h0);
    checkOutput("mid_rst_start", {31'b0, startBist}, 32'h0);
    wsp.shift_wr = 1'b0;
    wsp.wsi      = 1'b0;
    stepClock();
    rst_n = 1'b1;
    stepClock();
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    shiftChain(1'b1, 3, 32'h0, readBack);
    checkOutput("post_rst_wir", readBack, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end
endmodule
